serdes_quad_reset_ctrl: RTL

Quad-level reset sequencer for the ECP3 PCIe SERDES/PCS. Pulses the quad reset, waits for TX PLL lock with a bounded timeout and retry budget, then releases TX PCS lane resets and the enable for the per-channel RX reset state machine. It sits between the board reset and the RX reset sequencer, and exposes ready, fault and retry status to the PCIe core wrapper.

---
 rtl/serdes_quad_reset_ctrl_pkg.sv | 63 ++++++
 rtl/serdes_quad_reset_ctrl_if.sv | 27 ++
 rtl/serdes_quad_reset_ctrl_rst_seq_timer.sv | 28 ++
 rtl/serdes_quad_reset_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/serdes_quad_reset_ctrl_pkg.sv
// Shared types and constants for the SERDES quad reset sequencer.
// Holds the state encoding, status widths and the registered output decode.
package serdes_quad_reset_ctrl_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned RETRY_W  = 4;
    localparam int unsigned LOL_EV_W = 8;

    // Safe sequential encoding; codes 5..7 are unused and recover to QUAD_RESET.
    localparam logic [STATE_W-1:0] ENC_QUAD_RESET  = 3'd0;
    localparam logic [STATE_W-1:0] ENC_WAIT_PLOL   = 3'd1;
    localparam logic [STATE_W-1:0] ENC_WAIT_SETTLE = 3'd2;
    localparam logic [STATE_W-1:0] ENC_NORMAL      = 3'd3;
    localparam logic [STATE_W-1:0] ENC_FAULT       = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        ST_QUAD_RESET  = ENC_QUAD_RESET,
        ST_WAIT_PLOL   = ENC_WAIT_PLOL,
        ST_WAIT_SETTLE = ENC_WAIT_SETTLE,
        ST_NORMAL      = ENC_NORMAL,
        ST_FAULT       = ENC_FAULT
    } state_e;

    // Per-state control outputs; tx_pcs_rst is replicated across all lanes.
    typedef struct packed {
        logic rst_qd;
        logic tx_pcs_rst;
        logic rx_sm_rst_n;
        logic ready;
        logic fault;
    } ctrl_out_t;

    localparam ctrl_out_t OUT_RESET = '{
        rst_qd:      1'b1,
        tx_pcs_rst:  1'b1,
        rx_sm_rst_n: 1'b0,
        ready:       1'b0,
        fault:       1'b0
    };

    function automatic ctrl_out_t decode_out(input state_e st);
        ctrl_out_t o;
        o = OUT_RESET;
        case (st)
            ST_QUAD_RESET: o = OUT_RESET;
            ST_WAIT_PLOL,
            ST_WAIT_SETTLE: o.rst_qd = 1'b0;
            ST_NORMAL: begin
                o.rst_qd      = 1'b0;
                o.tx_pcs_rst  = 1'b0;
                o.rx_sm_rst_n = 1'b1;
                o.ready       = 1'b1;
            end
            ST_FAULT: begin
                o.rst_qd = 1'b0;
                o.fault  = 1'b1;
            end
            default: o = OUT_RESET;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/serdes_quad_reset_ctrl_if.sv
// Control/status bundle between the quad reset sequencer and the PCIe core wrapper.
// The slave side is the sequencer; the master side is its environment.
interface serdes_quad_reset_ctrl_if
    import serdes_quad_reset_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH = 4
);
    logic                tx_pll_lol_qd_s;
    logic                force_rst;
    logic                rst_qd_c;
    logic [NUM_CH-1:0]   tx_pcs_rst_ch_c;
    logic                rx_sm_rst_n;
    logic                ready;
    logic                fault;
    logic [RETRY_W-1:0]  retry_cnt;
    logic [LOL_EV_W-1:0] lol_events;

    modport master (
        output tx_pll_lol_qd_s, force_rst,
        input  rst_qd_c, tx_pcs_rst_ch_c, rx_sm_rst_n, ready, fault, retry_cnt, lol_events
    );

    modport slave (
        input  tx_pll_lol_qd_s, force_rst,
        output rst_qd_c, tx_pcs_rst_ch_c, rx_sm_rst_n, ready, fault, retry_cnt, lol_events
    );
endinterface

// File: rtl/serdes_quad_reset_ctrl_rst_seq_timer.sv
// Saturating dwell timer: counts while enabled until bit [INDEX] sets, then holds.
// clr has priority over en so a restart always begins from zero.
module rst_seq_timer #(
    parameter int unsigned INDEX = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam int unsigned CNT_W = INDEX + 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !cnt[INDEX]) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign done = cnt[INDEX];

endmodule

// File: rtl/serdes_quad_reset_ctrl.sv
// Quad-level reset sequencer for the ECP3 PCIe SERDES/PCS: quad reset pulse,
// bounded PLL-lock wait with retries, then release of TX PCS lanes and the RX reset FSM.
module serdes_quad_reset_ctrl
    import serdes_quad_reset_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned TIMER1_INDEX  = 2,
    parameter int unsigned TIMER2_INDEX  = 18,
    parameter int unsigned LOCK_TO_INDEX = 20,
    parameter int unsigned MAX_RETRY     = 7
) (
    input  logic                           refclkdiv2,
    input  logic                           rst,
    serdes_quad_reset_ctrl_if.slave        bus
);

    logic                lol_meta;
    logic                plol;
    state_e              state;
    state_e              state_nxt;
    ctrl_out_t           out_nxt;
    ctrl_out_t           out_q;
    logic [RETRY_W-1:0]  retry_cnt;
    logic [RETRY_W-1:0]  retry_inc;
    logic [LOL_EV_W-1:0] lol_events;
    logic                timeout_evt;
    logic                lol_evt;
    logic                t1_done;
    logic                t2_done;
    logic                to_done;
    logic                t1_clr;
    logic                t2_clr;
    logic                to_clr;
    logic                t1_en;
    logic                t2_en;
    logic                to_en;

    // PLL loss-of-lock synchronizer; both stages power up reporting "unlocked".
    always_ff @(posedge refclkdiv2 or posedge rst) begin
        if (rst) begin
            lol_meta <= 1'b1;
            plol     <= 1'b1;
        end else begin
            lol_meta <= bus.tx_pll_lol_qd_s;
            plol     <= lol_meta;
        end
    end

    // Timers clear whenever their state is not the next state, and on a forced restart.
    assign t1_en  = (state == ST_QUAD_RESET);
    assign t2_en  = (state == ST_WAIT_SETTLE);
    assign to_en  = (state == ST_WAIT_PLOL);
    assign t1_clr = (state_nxt != ST_QUAD_RESET)  || bus.force_rst;
    assign t2_clr = (state_nxt != ST_WAIT_SETTLE) || bus.force_rst;
    assign to_clr = (state_nxt != ST_WAIT_PLOL)   || bus.force_rst;

    rst_seq_timer #(.INDEX(TIMER1_INDEX)) u_t1 (
        .clk  (refclkdiv2),
        .rst  (rst),
        .clr  (t1_clr),
        .en   (t1_en),
        .done (t1_done)
    );

    rst_seq_timer #(.INDEX(TIMER2_INDEX)) u_t2 (
        .clk  (refclkdiv2),
        .rst  (rst),
        .clr  (t2_clr),
        .en   (t2_en),
        .done (t2_done)
    );

    rst_seq_timer #(.INDEX(LOCK_TO_INDEX)) u_to (
        .clk  (refclkdiv2),
        .rst  (rst),
        .clr  (to_clr),
        .en   (to_en),
        .done (to_done)
    );

    // Next-state and next-output decode; lock beats a coincident timeout.
    always_comb begin
        state_nxt   = state;
        timeout_evt = 1'b0;
        lol_evt     = 1'b0;
        retry_inc   = retry_cnt + RETRY_W'(1);

        if (bus.force_rst) begin
            state_nxt = ST_QUAD_RESET;
        end else begin
            case (state)
                ST_QUAD_RESET: begin
                    if (t1_done) state_nxt = ST_WAIT_PLOL;
                end
                ST_WAIT_PLOL: begin
                    if (!plol) begin
                        state_nxt = ST_WAIT_SETTLE;
                    end else if (to_done) begin
                        timeout_evt = 1'b1;
                        state_nxt   = (retry_inc == RETRY_W'(MAX_RETRY)) ? ST_FAULT : ST_QUAD_RESET;
                    end
                end
                ST_WAIT_SETTLE: begin
                    if (plol) begin
                        state_nxt = ST_WAIT_PLOL;
                    end else if (t2_done) begin
                        state_nxt = ST_NORMAL;
                    end
                end
                ST_NORMAL: begin
                    if (plol) begin
                        lol_evt   = 1'b1;
                        state_nxt = ST_QUAD_RESET;
                    end
                end
                ST_FAULT: state_nxt = ST_FAULT;
                default:  state_nxt = ST_QUAD_RESET;
            endcase
        end

        out_nxt = decode_out(state_nxt);
    end

    always_ff @(posedge refclkdiv2 or posedge rst) begin
        if (rst) begin
            state <= ST_QUAD_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs register the decode of the next state so they move with the state.
    always_ff @(posedge refclkdiv2 or posedge rst) begin
        if (rst) begin
            out_q <= OUT_RESET;
        end else begin
            out_q <= out_nxt;
        end
    end

    // Status counters never wrap.
    always_ff @(posedge refclkdiv2 or posedge rst) begin
        if (rst) begin
            retry_cnt  <= '0;
            lol_events <= '0;
        end else begin
            if (bus.force_rst) begin
                retry_cnt <= '0;
            end else if (timeout_evt && (retry_cnt != RETRY_W'(MAX_RETRY))) begin
                retry_cnt <= retry_inc;
            end
            if (lol_evt && (lol_events != {LOL_EV_W{1'b1}})) begin
                lol_events <= lol_events + LOL_EV_W'(1);
            end
        end
    end

    assign bus.rst_qd_c        = out_q.rst_qd;
    assign bus.tx_pcs_rst_ch_c = {NUM_CH{out_q.tx_pcs_rst}};
    assign bus.rx_sm_rst_n     = out_q.rx_sm_rst_n;
    assign bus.ready           = out_q.ready;
    assign bus.fault           = out_q.fault;
    assign bus.retry_cnt       = retry_cnt;
    assign bus.lol_events      = lol_events;

endmodule
